// File: rtl/wb_arbiter_if.sv
// Bus between the execute units / issue stage and the writeback arbiter.
// Carries the ALU and multiplier result streams, the hazard query and the register-file write port.
interface wb_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic          alu_valid_i;
    logic [4:0]    alu_rd_i;
    logic [31:0]   alu_value_i;
    logic          mul_valid_i;
    logic [4:0]    mul_rd_i;
    logic [31:0]   mul_value_i;
    logic          mul_full_o;
    logic [CW-1:0] fifo_count_o;
    logic [4:0]    query_rd_i;
    logic          query_hit_o;
    logic          rf_we_o;
    logic [4:0]    rf_waddr_o;
    logic [31:0]   rf_wdata_o;
    logic          overflow_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_value_i,
        input  mul_valid_i, mul_rd_i, mul_value_i,
        input  query_rd_i,
        output mul_full_o, fifo_count_o, query_hit_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o, overflow_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_value_i,
        output mul_valid_i, mul_rd_i, mul_value_i,
        output query_rd_i,
        input  mul_full_o, fifo_count_o, query_hit_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, overflow_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and multiplier results onto one register-file write port,
// buffering losing multiplier results in an in-order FIFO with a pending-destination lookup.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_rfWe;
    logic [4:0]    r_rfWaddr;
    logic [31:0]   r_rfWdata;
    logic [4:0]    r_fifoRd  [DEPTH];
    logic [31:0]   r_fifoVal [DEPTH];

    logic          w_aluSel;
    logic          w_mulOk;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_bypass;
    logic          w_pushReq;
    logic          w_push;
    logic          w_drop;
    logic          w_queryHit;
    logic [PW-1:0] w_scanIdx;

    // rd == 0 results are treated as if they never arrived.
    assign w_aluSel  = bus.alu_valid_i && (bus.alu_rd_i != 5'd0);
    assign w_mulOk   = bus.mul_valid_i && (bus.mul_rd_i != 5'd0);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = !w_aluSel && !w_empty;
    assign w_bypass  = !w_aluSel && w_empty && w_mulOk;
    assign w_pushReq = w_mulOk && !w_bypass;
    assign w_push    = w_pushReq && (!w_full || w_pop);
    assign w_drop    = w_pushReq && w_full && !w_pop;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rfWe     <= 1'b0;
            r_rfWaddr  <= 5'd0;
            r_rfWdata  <= 32'd0;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_aluSel) begin
                r_rfWe    <= 1'b1;
                r_rfWaddr <= bus.alu_rd_i;
                r_rfWdata <= bus.alu_value_i;
            end else if (w_pop) begin
                r_rfWe    <= 1'b1;
                r_rfWaddr <= r_fifoRd[r_rdPtr];
                r_rfWdata <= r_fifoVal[r_rdPtr];
            end else if (w_bypass) begin
                r_rfWe    <= 1'b1;
                r_rfWaddr <= bus.mul_rd_i;
                r_rfWdata <= bus.mul_value_i;
            end else begin
                r_rfWe <= 1'b0;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO payload needs no reset: only entries inside the count window are ever read.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifoRd[r_wrPtr]  <= bus.mul_rd_i;
            r_fifoVal[r_wrPtr] <= bus.mul_value_i;
        end
    end

    always_comb begin
        w_queryHit = 1'b0;
        w_scanIdx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_scanIdx = r_rdPtr + PW'(i);
            if ((CW'(i) < r_count) && (r_fifoRd[w_scanIdx] == bus.query_rd_i)) begin
                w_queryHit = 1'b1;
            end
        end
        if (r_rfWe && (r_rfWaddr == bus.query_rd_i)) begin
            w_queryHit = 1'b1;
        end
        if (bus.query_rd_i == 5'd0) begin
            w_queryHit = 1'b0;
        end
    end

    assign bus.query_hit_o  = w_queryHit;
    assign bus.mul_full_o   = w_full;
    assign bus.fifo_count_o = r_count;
    assign bus.rf_we_o      = r_rfWe;
    assign bus.rf_waddr_o   = r_rfWaddr;
    assign bus.rf_wdata_o   = r_rfWdata;
    assign bus.overflow_o   = r_overflow;
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and result buffer between the execute units and the register-file write port. Each cycle it merges the single-cycle ALU result stream with the multiplier result stream into one register-file write. Multiplier results that lose arbitration are held in a small in-order FIFO. A combinational pending-destination lookup lets the issue stage detect RAW/WAW hazards against results that are not yet written.

## Interface

Parameters:
- DEPTH, 4, multiplier result FIFO entries; power of two, at least 2.
- CW, $clog2(DEPTH)+1, count width (derived).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  reset; asynchronous, active-low.
- alu_valid_i  input  1  ALU result valid this cycle; no backpressure.
- alu_rd_i  input  5  ALU destination register.
- alu_value_i  input  32  ALU result.
- mul_valid_i  input  1  multiplier writeback valid (mul writeback_valid_o).
- mul_rd_i  input  5  multiplier destination register, tracked alongside the mul request.
- mul_value_i  input  32  multiplier result (mul writeback_value_o).
- mul_full_o  output  1  FIFO full (count == DEPTH); issue must not launch a multiply while high.
- fifo_count_o  output  CW  number of buffered multiplier results.
- query_rd_i  input  5  register number to check for pending writes.
- query_hit_o  output  1  query_rd_i matches a valid FIFO entry or an asserted rf write this cycle; 0 when query_rd_i == 0.
- rf_we_o  output  1  register-file write enable (registered).
- rf_waddr_o  output  5  register-file write address (registered).
- rf_wdata_o  output  32  register-file write data (registered).
- overflow_o  output  1  sticky error: a multiplier result was dropped.

## Operation

- A result with rd == 0 is discarded at input. It never enters the FIFO, never writes, and never raises overflow.
- Arbitration, evaluated every cycle, with at most one write selected:
  - Priority 1: ALU, when alu_valid_i is high and alu_rd_i != 0.
  - Priority 2: FIFO head, when count > 0. The head is popped.
  - Priority 3: bypass, when the FIFO is empty and the incoming mul result is valid with rd != 0. The result is written directly and not pushed.
- FIFO push: a valid mul result with rd != 0 is pushed unless it was taken by bypass.
- When full with a push pending:
  - If a pop happens in the same cycle, the push is accepted and count is unchanged.
  - If no pop happens (the ALU won), the result is dropped, overflow_o sets, and count stays at DEPTH.
- FIFO ordering is strict: oldest first. Bypass is only allowed when the FIFO is empty, so multiplier writes retire in program order.
- WAW/RAW ordering between ALU and buffered mul results is enforced by the issue stage through query_hit_o. The block does not reorder or compare ALU against FIFO contents.
- Pointers: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately, from 0 to DEPTH.
- query_hit_o is combinational over all valid FIFO entries plus (rf_we_o && rf_waddr_o == query_rd_i).
- overflow_o clears only on reset.

## Timing

- Reset (reset_i low, asynchronous): rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, count=0, pointers=0, overflow_o=0, mul_full_o=0. FIFO data is don't-care.
- Reset asserted mid-operation discards all buffered results, with no partial write. The first write can occur on the first rising edge after release.
- Latency:
  - ALU: input at edge N appears on rf_* after edge N+1.
  - Bypass: same 1-cycle latency as ALU.
  - Buffered result: written 1 cycle after the first cycle in which it is the head and alu_valid_i is low.
- Throughput: one register write per cycle. A FIFO drains at one entry per ALU-idle cycle.
- rf_we_o is low in any cycle with no selected source; rf_waddr_o and rf_wdata_o hold their last values.
- mul_full_o and fifo_count_o reflect the registered count and change only on clock edges.

## Test plan

- Reset and idle: hold reset_i low, then release with no valid inputs. rf_we_o=0, fifo_count_o=0, overflow_o=0 for 10 cycles.
- Bypass: FIFO empty, mul_valid_i=1, rd=5, value=0x0000_00A5, ALU idle. Next cycle rf_we_o=1, waddr=5, wdata=0xA5, and count stays 0.
- Conflict and ordering:
  - Stimulus: ALU (rd=3, 0x11) and mul (rd=7, 0x22) in the same cycle, then mul (rd=8, 0x33) while the ALU is busy, then the ALU goes idle.
  - Writes in order: r3=0x11, then r7=0x22, then r8=0x33.
  - count peaks at 2, and query_rd_i=8 gives hit=1 until r8 is written.
- Full and overflow, DEPTH=4:
  - Stimulus: ALU valid continuously while 5 mul results arrive.
  - mul_full_o=1 after the 4th; the 5th is dropped and overflow_o=1.
  - After the ALU idles, exactly 4 mul writes occur in order.
- Full with simultaneous pop: FIFO full, ALU idle, mul valid. A head write occurs, the push is accepted, count stays 4, and overflow_o stays 0.
- x0 and reset mid-drain:
  - mul with rd=0 causes no write and no push.
  - Assert reset_i with 3 entries buffered: count=0 and rf_we_o=0 immediately, and no stale write after release.
